// File: rtl/gb_dma_pkg.sv
// Shared types and constants for the GB OAM DMA engine and bus arbiter.
package gb_dma_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        RD    = 2'd2,
        WR    = 2'd3
    } dma_state_t;

    localparam int          DMA_LEN      = 160;
    localparam logic [7:0]  LAST_IDX     = 8'(DMA_LEN - 1);
    localparam logic [15:0] DMA_REG_ADDR = 16'hFF46;
    localparam logic [15:0] OAM_BASE     = 16'hFE00;
    localparam logic [15:0] OAM_TOP      = 16'hFE9F;
    localparam logic [7:0]  ECHO_BASE    = 8'hE0;
    localparam logic [7:0]  OPEN_BUS     = 8'hFF;

    // Sources in E0-FF alias work RAM at C0-DF.
    function automatic logic [7:0] mirror_src(input logic [7:0] v);
        return (v >= ECHO_BASE) ? (v - 8'h20) : v;
    endfunction

endpackage

// File: rtl/gb_dma_seq.sv
// DMA sequencer: start detect, state machine, byte index, source page, data capture.
import gb_dma_pkg::*;

module gb_dma_seq (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [15:0] cpu_a,
    input  logic [7:0]  cpu_dout,
    input  logic        cpu_mreq_n,
    input  logic        cpu_wr_n,
    input  logic [7:0]  mem_di,
    output dma_state_t  state,
    output logic [7:0]  idx,
    output logic [7:0]  src_hi,
    output logic [7:0]  dma_reg,
    output logic [7:0]  data_q
);

    dma_state_t state_nxt;
    logic       wstb;
    logic       wstb_q;
    logic       trig;

    // One trigger per CPU write, however long the strobe is held.
    assign wstb = ~cpu_mreq_n & ~cpu_wr_n & (cpu_a == DMA_REG_ADDR);
    assign trig = wstb & ~wstb_q;

    // State register.
    always_ff @(posedge clk) begin
        if (!reset_n) state <= IDLE;
        else          state <= state_nxt;
    end

    // Next state; a new trigger restarts from any state and wins over the advance.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:  state_nxt = IDLE;
            START: state_nxt = RD;
            RD:    state_nxt = WR;
            WR:    state_nxt = (idx == LAST_IDX) ? IDLE : RD;
            default: state_nxt = IDLE;
        endcase
        if (trig) state_nxt = START;
    end

    // Register file, index counter and the byte held between RD and WR.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            wstb_q  <= 1'b0;
            idx     <= 8'd0;
            src_hi  <= 8'd0;
            dma_reg <= 8'd0;
            data_q  <= 8'd0;
        end else begin
            wstb_q <= wstb;
            if (trig) begin
                dma_reg <= cpu_dout;
                src_hi  <= mirror_src(cpu_dout);
                idx     <= 8'd0;
            end else begin
                if (state == RD) data_q <= mem_di;
                // Index returns to 0 after the last byte so it never leaves 0..159.
                if (state == WR) idx <= (idx == LAST_IDX) ? 8'd0 : idx + 8'd1;
            end
        end
    end

endmodule

// File: rtl/gb_oam_dma_arb.sv
// OAM DMA top: muxes memory/OAM ports between CPU and DMA and selects CPU read data.
import gb_dma_pkg::*;

module gb_oam_dma_arb (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [15:0] cpu_a,
    input  logic [7:0]  cpu_dout,
    input  logic        cpu_mreq_n,
    input  logic        cpu_rd_n,
    input  logic        cpu_wr_n,
    output logic [7:0]  cpu_di,
    output logic [15:0] mem_a,
    output logic [7:0]  mem_dout,
    output logic        mem_rd_n,
    output logic        mem_wr_n,
    input  logic [7:0]  mem_di,
    output logic [7:0]  oam_a,
    output logic        oam_we,
    output logic [7:0]  oam_wdata,
    input  logic [7:0]  oam_rdata,
    output logic        dma_active,
    output logic [7:0]  dma_reg
);

    dma_state_t state;
    logic [7:0] idx;
    logic [7:0] src_hi;
    logic [7:0] data_q;
    logic       cpu_lo;
    logic       cpu_oam;
    logic       dma_bus;

    gb_dma_seq u_seq (
        .clk        (clk),
        .reset_n    (reset_n),
        .cpu_a      (cpu_a),
        .cpu_dout   (cpu_dout),
        .cpu_mreq_n (cpu_mreq_n),
        .cpu_wr_n   (cpu_wr_n),
        .mem_di     (mem_di),
        .state      (state),
        .idx        (idx),
        .src_hi     (src_hi),
        .dma_reg    (dma_reg),
        .data_q     (data_q)
    );

    assign cpu_lo     = (cpu_a < OAM_BASE);
    assign cpu_oam    = (cpu_a >= OAM_BASE) && (cpu_a <= OAM_TOP);
    assign dma_bus    = (state == RD) || (state == WR);
    assign dma_active = (state != IDLE);

    // Bus ownership: DMA drives mem/OAM in RD/WR, otherwise the CPU passes through by region.
    always_comb begin
        mem_a     = cpu_a;
        mem_dout  = cpu_dout;
        mem_rd_n  = 1'b1;
        mem_wr_n  = 1'b1;
        oam_a     = cpu_a[7:0];
        oam_we    = 1'b0;
        oam_wdata = cpu_dout;
        cpu_di    = OPEN_BUS;
        if (dma_bus) begin
            mem_a = {src_hi, idx};
            if (state == RD) mem_rd_n = 1'b0;
            if (state == WR) begin
                oam_a     = idx;
                oam_wdata = data_q;
                oam_we    = 1'b1;
            end
            if (cpu_a == DMA_REG_ADDR) cpu_di = dma_reg;
        end else begin
            if (cpu_lo) begin
                mem_rd_n = cpu_mreq_n | cpu_rd_n;
                mem_wr_n = cpu_mreq_n | cpu_wr_n;
                cpu_di   = mem_di;
            end else if (cpu_oam) begin
                oam_we = ~cpu_mreq_n & ~cpu_wr_n;
                cpu_di = oam_rdata;
            end else if (cpu_a == DMA_REG_ADDR) begin
                cpu_di = dma_reg;
            end
        end
    end

endmodule

// File: tb/tb_gb_oam_dma_arb.sv
// Directed bench for gb_oam_dma_arb with behavioural memory and OAM models.
module tb_gb_oam_dma_arb;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [15:0] cpu_a;
    logic [7:0]  cpu_dout;
    logic        cpu_mreq_n, cpu_rd_n, cpu_wr_n;
    logic [7:0]  cpu_di;
    logic [15:0] mem_a;
    logic [7:0]  mem_dout;
    logic        mem_rd_n, mem_wr_n;
    logic [7:0]  mem_di;
    logic [7:0]  oam_a;
    logic        oam_we;
    logic [7:0]  oam_wdata;
    logic [7:0]  oam_rdata;
    logic        dma_active;
    logic [7:0]  dma_reg;

    logic [7:0]  oam_m [256];

    int checks = 0, errors = 0;
    int we_cnt = 0, act_cnt = 0, rd_cnt = 0;
    logic [15:0] first_rd = 16'h0, last_rd = 16'h0;
    int we_base, act_base;

    always #5 clk = ~clk;

    gb_oam_dma_arb dut (
        .clk(clk), .reset_n(reset_n),
        .cpu_a(cpu_a), .cpu_dout(cpu_dout), .cpu_mreq_n(cpu_mreq_n),
        .cpu_rd_n(cpu_rd_n), .cpu_wr_n(cpu_wr_n), .cpu_di(cpu_di),
        .mem_a(mem_a), .mem_dout(mem_dout), .mem_rd_n(mem_rd_n), .mem_wr_n(mem_wr_n),
        .mem_di(mem_di), .oam_a(oam_a), .oam_we(oam_we), .oam_wdata(oam_wdata),
        .oam_rdata(oam_rdata), .dma_active(dma_active), .dma_reg(dma_reg)
    );

    // Memory contents: page C1 holds i^5A; other pages are distinct per page.
    function automatic logic [7:0] memv(input logic [15:0] a);
        return a[7:0] ^ a[15:8] ^ 8'h5A ^ 8'hC1;
    endfunction

    assign mem_di    = mem_rd_n ? 8'h00 : memv(mem_a);
    assign oam_rdata = oam_m[oam_a];

    always @(posedge clk) if (oam_we === 1'b1) oam_m[oam_a] <= oam_wdata;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    // Runs n cycles, sampling outputs 1ns after each falling edge where inputs change.
    task automatic cyc(input int n);
        for (int k = 0; k < n; k++) begin
            #1;
            if (oam_we === 1'b1) we_cnt++;
            if (dma_active === 1'b1) act_cnt++;
            if (mem_rd_n === 1'b0) begin
                if (rd_cnt == 0) first_rd = mem_a;
                last_rd = mem_a;
                rd_cnt++;
            end
            @(negedge clk);
        end
    endtask

    task automatic chk_oam(input string tag, input logic [15:0] base, input int lo, input int hi);
        int bad;
        bad = 0;
        for (int i = lo; i <= hi; i++)
            if (oam_m[i] !== memv(base + 16'(i))) bad++;
        chk(tag, bad, 0);
    endtask

    task automatic bus_idle();
        cpu_a = 16'h0000; cpu_dout = 8'h00;
        cpu_mreq_n = 1'b1; cpu_rd_n = 1'b1; cpu_wr_n = 1'b1;
    endtask

    task automatic set_wr(input logic [15:0] a, input logic [7:0] d);
        cpu_a = a; cpu_dout = d; cpu_mreq_n = 1'b0; cpu_rd_n = 1'b1; cpu_wr_n = 1'b0;
    endtask

    task automatic set_rd(input logic [15:0] a);
        cpu_a = a; cpu_dout = 8'h00; cpu_mreq_n = 1'b0; cpu_rd_n = 1'b0; cpu_wr_n = 1'b1;
    endtask

    initial begin
        reset_n = 1'b0;
        bus_idle();
        repeat (3) @(negedge clk);
        #1;
        chk("rst_active", dma_active, 0);
        chk("rst_dma_reg", dma_reg, 8'h00);
        chk("rst_oam_we", oam_we, 0);
        chk("rst_mem_rd_n", mem_rd_n, 1);
        chk("rst_mem_wr_n", mem_wr_n, 1);
        reset_n = 1'b1;
        @(negedge clk);

        // Idle pass-through and the unusable FEA0 hole.
        set_rd(16'hC000); #1;
        chk("idle_rd_mem_strobe", mem_rd_n, 0);
        chk("idle_rd_data", cpu_di, memv(16'hC000));
        set_rd(16'hFEA0); #1;
        chk("idle_fea0_rd", cpu_di, 8'hFF);
        set_wr(16'hFEA0, 8'h33); #1;
        chk("idle_fea0_we", oam_we, 0);
        chk("idle_fea0_memwr", mem_wr_n, 1);
        bus_idle();
        @(negedge clk);

        // Basic transfer from C100.
        we_base = we_cnt; act_base = act_cnt; rd_cnt = 0;
        set_wr(16'hFF46, 8'hC1);
        cyc(1);
        bus_idle();
        cyc(330);
        chk("t1_active_cycles", act_cnt - act_base, 321);
        chk("t1_we_count", we_cnt - we_base, 160);
        chk("t1_first_rd", first_rd, 16'hC100);
        chk("t1_last_rd", last_rd, 16'hC19F);
        chk("t1_done", dma_active, 0);
        chk_oam("t1_oam", 16'hC100, 0, 159);

        // Long write strobe gives exactly one transfer.
        we_base = we_cnt; act_base = act_cnt; rd_cnt = 0;
        set_wr(16'hFF46, 8'h80);
        cyc(3);
        bus_idle();
        cyc(330);
        chk("t2_we_count", we_cnt - we_base, 160);
        chk("t2_active_cycles", act_cnt - act_base, 321);
        chk("t2_first_rd", first_rd, 16'h8000);
        chk_oam("t2_oam", 16'h8000, 0, 159);
        set_rd(16'hFF46); #1;
        chk("t2_dma_reg_rd", cpu_di, 8'h80);
        chk("t2_dma_reg", dma_reg, 8'h80);
        bus_idle();
        @(negedge clk);

        // CPU lockout while the copy runs; OAM byte 0x10 is already DMA-written.
        set_wr(16'hFF46, 8'h81);
        cyc(1);
        bus_idle();
        cyc(40);
        set_rd(16'hC000); #1;
        chk("t3_active", dma_active, 1);
        chk("t3_rd_c000", cpu_di, 8'hFF);
        chk("t3_c000_memrd", (mem_rd_n === 1'b1) || (mem_a[15:8] === 8'h81), 1);
        chk("t3_c000_memwr", mem_wr_n, 1);
        cyc(1);
        set_rd(16'hFE10); #1;
        chk("t3_rd_fe10", cpu_di, 8'hFF);
        cyc(1);
        set_wr(16'hFE10, 8'hEE); #1;
        chk("t3_wr_oam_a", (oam_we === 1'b0) || (oam_a !== 8'h10), 1);
        chk("t3_wr_memwr", mem_wr_n, 1);
        cyc(2);
        bus_idle();
        cyc(300);
        chk("t3_oam10", oam_m[8'h10], memv(16'h8110));
        chk_oam("t3_oam", 16'h8100, 0, 159);

        // Restart at idx 50 from D000.
        set_wr(16'hFF46, 8'h90);
        cyc(1);
        bus_idle();
        cyc(101);
        #1;
        chk("t4_idx50_addr", mem_a, 16'h9032);
        we_base = we_cnt;
        set_wr(16'hFF46, 8'hD0);
        cyc(1);
        bus_idle();
        rd_cnt = 0;
        cyc(330);
        chk("t4_we_count", we_cnt - we_base, 160);
        chk("t4_first_rd", first_rd, 16'hD000);
        chk("t4_last_rd", last_rd, 16'hD09F);
        chk_oam("t4_oam", 16'hD000, 0, 159);

        // Echo source F3 reads from D300.
        set_wr(16'hFF46, 8'hF3);
        cyc(1);
        bus_idle();
        rd_cnt = 0;
        cyc(330);
        chk("t5_first_rd", first_rd, 16'hD300);
        chk("t5_last_rd", last_rd, 16'hD39F);
        chk("t5_dma_reg", dma_reg, 8'hF3);
        chk_oam("t5_oam", 16'hD300, 0, 159);

        // Reset at idx 80 aborts the copy and keeps bytes written so far.
        set_wr(16'hFF46, 8'hA0);
        cyc(1);
        bus_idle();
        cyc(161);
        #1;
        chk("t6_idx80_addr", mem_a, 16'hA050);
        reset_n = 1'b0;
        cyc(1);
        reset_n = 1'b1;
        #1;
        chk("t6_active", dma_active, 0);
        chk("t6_oam_we", oam_we, 0);
        chk("t6_dma_reg", dma_reg, 8'h00);
        we_base = we_cnt;
        cyc(20);
        chk("t6_no_more_we", we_cnt - we_base, 0);
        chk_oam("t6_oam_new", 16'hA000, 0, 79);
        chk_oam("t6_oam_kept", 16'hD300, 80, 159);
        set_rd(16'hFE00); #1;
        chk("t6_rd_fe00", cpu_di, memv(16'hA000));
        bus_idle();
        @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
